// File: rtl/block_frame_writer.sv
// Raster block-stream writer for the VGA double buffer; optional CLEAR pass under BLOCK_FRAME_WRITER_CLEAR_EN.
// One cycle from handshake to write strobe; in_ready drops outside FILL and in the swap cycle, wren never stalls.
module block_frame_writer #(
  parameter int HBLOCKS = 64,
  parameter int VBLOCKS = 48,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8
`ifdef BLOCK_FRAME_WRITER_CLEAR_EN
  ,
  parameter logic [DATA_W-1:0] BG_COLOR = '0
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] pixel_data_out,
  output logic              wren,
  output logic              frame_done,
  output logic [7:0]        torn_count
);

  localparam int COL_W = (HBLOCKS > 1) ? $clog2(HBLOCKS) : 1;
  localparam int ROW_W = (VBLOCKS > 1) ? $clog2(VBLOCKS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(HBLOCKS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(VBLOCKS - 1);

  typedef enum logic [1:0] {IDLE, FILL, CLEAR, DONE} state_t;

`ifdef BLOCK_FRAME_WRITER_CLEAR_EN
  localparam state_t START_ST = CLEAR;
`else
  localparam state_t START_ST = FILL;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              swap_cond_q;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic [7:0]        torn_q, torn_d;

  logic              swap_cond;
  logic              swap_evt;
  logic              accept;
  logic              last_blk;
  logic [COL_W-1:0]  col_nx;
  logic [ROW_W-1:0]  row_nx;
  logic [7:0]        torn_inc;

  // Edge-detect the origin so a frozen counter yields a single swap event
  assign swap_cond = (hc == 10'd0) && (vc == 10'd0);
  assign swap_evt  = swap_cond && !swap_cond_q;

  assign in_ready = (state_q == FILL) && !swap_evt;
  assign accept   = in_valid && in_ready;
  assign last_blk = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign col_nx   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
  assign row_nx   = (col_q == COL_LAST) ? row_q + ROW_W'(1) : row_q;
  assign torn_inc = (torn_q == 8'hFF) ? torn_q : torn_q + 8'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    torn_d  = torn_q;
    case (state_q)
      IDLE, DONE: begin
        if (swap_evt) begin
          state_d = START_ST;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FILL: begin
        if (swap_evt) begin
          torn_d  = torn_inc;
          state_d = START_ST;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end else if (accept) begin
          wren_d = 1'b1;
          data_d = in_data;
          if (in_sof) begin
            // Start-of-frame marker realigns the raster to block (0,0)
            waddr_d = '0;
            addr_d  = ADDR_W'(1);
            col_d   = COL_W'(1);
            row_d   = '0;
          end else begin
            waddr_d = addr_q;
            addr_d  = addr_q + ADDR_W'(1);
            col_d   = col_nx;
            row_d   = row_nx;
            if (last_blk) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
`ifdef BLOCK_FRAME_WRITER_CLEAR_EN
      CLEAR: begin
        if (swap_evt) begin
          torn_d = torn_inc;
          addr_d = '0;
          col_d  = '0;
          row_d  = '0;
        end else begin
          wren_d  = 1'b1;
          waddr_d = addr_q;
          data_d  = BG_COLOR;
          addr_d  = addr_q + ADDR_W'(1);
          col_d   = col_nx;
          row_d   = row_nx;
          if (last_blk) begin
            state_d = FILL;
            addr_d  = '0;
            col_d   = '0;
            row_d   = '0;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      swap_cond_q <= 1'b0;
      wren_q      <= 1'b0;
      waddr_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      torn_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      swap_cond_q <= swap_cond;
      wren_q      <= wren_d;
      waddr_q     <= waddr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      torn_q      <= torn_d;
    end
  end

  assign write_addr     = waddr_q;
  assign pixel_data_out = data_q;
  assign wren           = wren_q;
  assign frame_done     = done_q;
  assign torn_count     = torn_q;

endmodule

// File: tb/tb_block_frame_writer.sv
// Directed bench for block_frame_writer: vector table plus multi-cycle frame, swap, resync and reset sequences.
module tb_block_frame_writer;

  logic        clk;
  logic        in_reset;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_ready;
  logic [11:0] write_addr;
  logic [7:0]  pixel_data_out;
  logic        wren;
  logic        frame_done;
  logic [7:0]  torn_count;

  int checks   = 0;
  int failures = 0;
  int nxt      = 0;

  block_frame_writer dut (
    .clk            (clk),
    .reset          (in_reset),
    .hc             (hc),
    .vc             (vc),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .in_ready       (in_ready),
    .write_addr     (write_addr),
    .pixel_data_out (pixel_data_out),
    .wren           (wren),
    .frame_done     (frame_done),
    .torn_count     (torn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied in a cycle; e_rdy is in_ready during it, the rest are outputs after its closing edge.
  typedef struct {
    bit rst;
    int h;
    int v;
    bit vld;
    int dat;
    bit sof;
    bit e_rdy;
    bit e_wren;
    bit chk_a;
    int e_addr;
    int e_data;
    bit e_done;
    int e_torn;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input int exp_a, input string nm);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    #1;
    chk({nm, "_rdy"}, in_ready, 1);
    tick;
    chk({nm, "_wren"}, wren, 1);
    chk({nm, "_addr"}, write_addr, exp_a);
    chk({nm, "_data"}, pixel_data_out, d);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_swap(input int exp_torn, input string nm);
    hc       = 10'd0;
    vc       = 10'd0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    chk({nm, "_rdy"}, in_ready, 0);
    tick;
    chk({nm, "_wren"}, wren, 0);
    chk({nm, "_torn"}, torn_count, exp_torn);
    hc       = 10'd5;
    vc       = 10'd5;
    in_valid = 1'b0;
  endtask

  task automatic fill_to(input int target);
    while (nxt < target) begin
      beat(nxt[7:0], 1'b0, nxt, "fill");
      nxt++;
    end
  endtask

  initial begin
    in_reset = 1'b1;
    hc       = 10'd5;
    vc       = 10'd5;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_sof   = 1'b0;
    repeat (2) tick;
    chk("rst_wren", wren, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", pixel_data_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_torn", torn_count, 0);
    chk("rst_rdy", in_ready, 0);

`ifdef BLOCK_FRAME_WRITER_CLEAR_EN
    begin
      int n;
      int bad;
      in_reset = 1'b0;
      do_swap(0, "clr_sw");
      n   = 0;
      bad = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        #0;
        if (in_ready) break;
        tick;
        if (wren) begin
          if (write_addr != 12'(n) || pixel_data_out != 8'h00) bad++;
          n++;
        end
      end
      in_valid = 1'b0;
      chk("clr_count", n, 3072);
      chk("clr_bad", bad, 0);
      beat(8'h77, 1'b0, 0, "clr_fill0");
      do_swap(1, "clr_torn");
    end
`else
    //        rst h  v  vld dat    sof rdy wren chka addr data   done torn
    vt[0]  = '{1, 5, 5, 0, 'h00, 0, 0, 0, 1, 0, 'h00, 0, 0};
    vt[1]  = '{0, 0, 0, 1, 'h11, 0, 0, 0, 0, 0, 'h00, 0, 0};
    vt[2]  = '{0, 0, 0, 1, 'h21, 0, 1, 1, 1, 0, 'h21, 0, 0};
    vt[3]  = '{0, 1, 0, 1, 'h22, 0, 1, 1, 1, 1, 'h22, 0, 0};
    vt[4]  = '{0, 5, 5, 0, 'h00, 0, 1, 0, 0, 0, 'h00, 0, 0};
    vt[5]  = '{0, 5, 5, 1, 'h33, 1, 1, 1, 1, 0, 'h33, 0, 0};
    vt[6]  = '{0, 5, 5, 1, 'h44, 0, 1, 1, 1, 1, 'h44, 0, 0};
    vt[7]  = '{0, 0, 0, 1, 'h55, 0, 0, 0, 0, 0, 'h00, 0, 1};
    vt[8]  = '{0, 0, 0, 1, 'h66, 0, 1, 1, 1, 0, 'h66, 0, 1};
    vt[9]  = '{0, 0, 0, 1, 'h77, 0, 1, 1, 1, 1, 'h77, 0, 1};
    vt[10] = '{0, 5, 5, 1, 'h88, 0, 1, 1, 1, 2, 'h88, 0, 1};
    vt[11] = '{1, 5, 5, 1, 'h99, 0, 1, 0, 1, 0, 'h00, 0, 0};
    vt[12] = '{0, 5, 5, 1, 'h9B, 0, 0, 0, 0, 0, 'h00, 0, 0};
    vt[13] = '{0, 0, 0, 1, 'h9C, 0, 0, 0, 0, 0, 'h00, 0, 0};
    vt[14] = '{0, 3, 0, 1, 'h9A, 0, 1, 1, 1, 0, 'h9A, 0, 0};
    vt[15] = '{0, 5, 5, 1, 'hAB, 0, 1, 1, 1, 1, 'hAB, 0, 0};
    vt[16] = '{0, 0, 0, 1, 'hCD, 0, 0, 0, 0, 0, 'h00, 0, 1};
    for (int i = 0; i < 17; i++) begin
      in_reset = vt[i].rst;
      hc       = 10'(vt[i].h);
      vc       = 10'(vt[i].v);
      in_valid = vt[i].vld;
      in_data  = 8'(vt[i].dat);
      in_sof   = vt[i].sof;
      #1;
      chk($sformatf("v%0d_rdy", i), in_ready, vt[i].e_rdy);
      tick;
      chk($sformatf("v%0d_wren", i), wren, vt[i].e_wren);
      chk($sformatf("v%0d_done", i), frame_done, vt[i].e_done);
      chk($sformatf("v%0d_torn", i), torn_count, vt[i].e_torn);
      if (vt[i].chk_a) begin
        chk($sformatf("v%0d_addr", i), write_addr, vt[i].e_addr);
        chk($sformatf("v%0d_data", i), pixel_data_out, vt[i].e_data);
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    hc       = 10'd5;
    vc       = 10'd5;

    // Complete frame, back to back
    in_reset = 1'b1;
    tick;
    in_reset = 1'b0;
    do_swap(0, "ff_sw");
    for (int i = 0; i < 3072; i++) begin
      beat(8'(i), 1'b0, i, "ff");
      chk("ff_done", frame_done, (i == 3071));
    end
    in_valid = 1'b1;
    #1;
    chk("ff_rdy_after", in_ready, 0);
    tick;
    chk("ff_wren_after", wren, 0);
    chk("ff_done_after", frame_done, 0);
    chk("ff_torn", torn_count, 0);
    in_valid = 1'b0;

    // Swap after DONE, then a torn swap after 1000 beats
    do_swap(0, "sw_done");
    beat(8'h5A, 1'b0, 0, "sw_done_first");
    nxt = 1;
    fill_to(1000);
    do_swap(1, "sw_torn");
    beat(8'h11, 1'b0, 0, "sw_torn_first");
    nxt = 1;
    fill_to(3);

    // Origin held for five clocks: one restart only
    begin
      int  nrdy;
      logic r;
      nrdy = 0;
      hc   = 10'd0;
      vc   = 10'd0;
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        in_data  = 8'(k + 1);
        #1;
        r = in_ready;
        tick;
        if (!r) begin
          nrdy++;
          nxt = 0;
          chk("hold_wren0", wren, 0);
        end else begin
          chk("hold_wren", wren, 1);
          chk("hold_addr", write_addr, nxt);
          nxt++;
        end
      end
      in_valid = 1'b0;
      hc       = 10'd5;
      vc       = 10'd5;
      chk("hold_nrdy", nrdy, 1);
      chk("hold_torn", torn_count, 2);
      chk("hold_nxt", nxt, 4);
    end

    // Start-of-frame resync at address 200
    fill_to(200);
    beat(8'hA5, 1'b1, 0, "sof");
    beat(8'h3C, 1'b0, 1, "sof_next");
    nxt = 2;

    // Reset mid-fill at address 500
    fill_to(500);
    in_reset = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick;
    chk("mrst_wren", wren, 0);
    chk("mrst_addr", write_addr, 0);
    chk("mrst_data", pixel_data_out, 0);
    chk("mrst_torn", torn_count, 0);
    chk("mrst_done", frame_done, 0);
    in_reset = 1'b0;
    #1;
    chk("mrst_rdy", in_ready, 0);
    tick;
    chk("mrst_wren2", wren, 0);
    in_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
